// File: rtl/mult_iter.sv
// mult_iter: iterative shift-add multiplier for the RV32M/RV64M execute stage.
// Retires STEP multiplier bits per cycle using operand magnitudes. The product
// sign is applied once, when the last step completes. The result is either the
// low half (MUL) or the high half (MULH, MULHSU, MULHU) of the 2*XLEN product.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready. The producer holds valid and its payload steady until that
// edge, and ready never depends on valid from the same side. in_ready is 1 in
// IDLE, and also in DONE while out_ready is 1, which allows back-to-back issue.
// in_ready is forced to 0 while flush is high. out_valid is 1 exactly in DONE,
// and result holds steady until the consumer takes it.
module mult_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);

    localparam int NSTEP = XLEN / STEP;
    localparam int CNT_W = $clog2(NSTEP + 1);

    // Opcode encoding follows the RV M-extension funct3 order.
    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!((STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) &&
              (XLEN == 32 || XLEN == 64) && (XLEN % STEP == 0))) begin : g_bad_param
            $error("mult_iter: illegal XLEN/STEP combination");
        end
    endgenerate

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    // Upper half is the running partial sum. Lower half starts as |b| and shifts
    // out STEP bits per cycle, while product bits shift in from above.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mag_a;
    logic              neg_q;
    logic              hi_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              cap_sign_a;
    logic              cap_sign_b;
    logic [XLEN-1:0]   cap_mag_a;
    logic [XLEN-1:0]   cap_mag_b;
    logic [XLEN+STEP-1:0] pp;
    logic [XLEN+STEP-1:0] sum;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_next;

    assign in_ready  = !flush && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign result    = result_q;
    assign state_dbg = state;

    // Operand conditioning at accept: signedness per op, then magnitudes.
    // The magnitude of an XLEN+1-bit sign-extended value always fits in XLEN bits.
    always_comb begin
        cap_sign_a = ((op == OP_MULH) || (op == OP_MULHSU)) && op_a[XLEN-1];
        cap_sign_b = (op == OP_MULH) && op_b[XLEN-1];
        cap_mag_a  = cap_sign_a ? -op_a : op_a;
        cap_mag_b  = cap_sign_b ? -op_b : op_b;
    end

    // One shift-add step, plus the sign-corrected, half-selected result for the final step.
    always_comb begin
        pp       = {{STEP{1'b0}}, mag_a} * {{XLEN{1'b0}}, acc[STEP-1:0]};
        sum      = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
        acc_step = {sum, acc[XLEN-1:STEP]};
        prod     = (neg_q && (|acc_step)) ? -acc_step : acc_step;
        res_next = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    // Control FSM: flush beats everything; a DONE handshake may re-enter CALC directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state <= S_CALC;
                S_CALC: if (cnt == CNT_W'(1)) state <= S_DONE;
                S_DONE: if (out_ready) state <= accept ? S_CALC : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: capture on accept, iterate in CALC, latch the result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            mag_a    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            result_q <= '0;
        end else if (!flush) begin
            if (accept) begin
                cnt   <= CNT_W'(NSTEP);
                acc   <= {{XLEN{1'b0}}, cap_mag_b};
                mag_a <= cap_mag_a;
                neg_q <= cap_sign_a ^ cap_sign_b;
                hi_q  <= (op != OP_MUL);
            end else if (state == S_CALC) begin
                cnt <= cnt - CNT_W'(1);
                acc <= acc_step;
                if (cnt == CNT_W'(1)) begin
                    result_q <= res_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// tb_mult_iter: directed and random checks of mult_iter. The main instance is
// XLEN=32, STEP=2. A second instance is XLEN=64, STEP=8. Results are compared
// against a signed wide-arithmetic reference model.
module tb_mult_iter;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT: XLEN=32, STEP=2 ----------------
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  op, state_dbg;
    logic [31:0] op_a, op_b, result;

    mult_iter #(.XLEN(32), .STEP(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .state_dbg(state_dbg)
    );

    // ---------------- DUT: XLEN=64, STEP=8 ----------------
    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [1:0]  w_op, w_state_dbg;
    logic [63:0] w_op_a, w_op_b, w_result;

    mult_iter #(.XLEN(64), .STEP(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .op(w_op), .op_a(w_op_a), .op_b(w_op_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .result(w_result), .state_dbg(w_state_dbg)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] ea, eb;
        logic signed [65:0] p;
        ea = $signed({((o == OP_MULH) || (o == OP_MULHSU)) && a[31], a});
        eb = $signed({(o == OP_MULH) && b[31], b});
        p  = ea * eb;
        return (o == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [63:0] ref64(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0]  ea, eb;
        logic signed [129:0] p;
        ea = $signed({((o == OP_MULH) || (o == OP_MULHSU)) && a[63], a});
        eb = $signed({(o == OP_MULH) && b[63], b});
        p  = ea * eb;
        return (o == OP_MUL) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'h1;
            2: return {64{1'b1}};
            3: return {1'b1, 63'h0};
            4: return {1'b0, {63{1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Issue one op from IDLE. Then wait for the result and complete the handshake
    // after `stall` cycles of back-pressure. lat counts cycles from the accept edge,
    // and is -1 if no result arrives within the bound.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int stall, output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op = 2'($urandom);
        out_ready = (stall == 0);
        lat = -1; res = 'x;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c + 0;
                res = result;
                break;
            end
        end
        if (lat > 0) begin
            repeat (stall) @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic w_run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                            output logic [63:0] res, output int lat);
        @(negedge clk);
        w_op = o; w_op_a = a; w_op_b = b; w_in_valid = 1'b1; w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_op_a = {$urandom, $urandom}; w_op_b = {$urandom, $urandom};
        lat = -1; res = 'x;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (w_out_valid) begin
                lat = c + 0;
                res = w_result;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        chk_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else pass_cnt++;
        chk_cnt++; if (w_in_ready !== 1'b1) $display("FAIL reset_w_in_ready: got %b expected 1", w_in_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] r;
        int lat;
        run_op(OP_MUL, 32'd7, 32'd6, 0, r, lat);
        chk_cnt++; if (r !== 32'h0000_002A) $display("FAIL basic_result: got %h expected 0000002a", r); else pass_cnt++;
        chk_cnt++; if (lat !== 17) $display("FAIL basic_latency: got %0d expected 17", lat); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_corners();
        logic [1:0]  c_op  [5] = '{OP_MULH, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        logic [31:0] c_a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] c_exp [5] = '{32'h0000_0000, 32'h0000_0001, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(c_op[i], c_a[i], c_a[i], 0, r, lat);
            chk_cnt++; if (r !== c_exp[i]) $display("FAIL corner_%0d_result: got %h expected %h", i, r, c_exp[i]); else pass_cnt++;
            chk_cnt++; if (lat !== 17) $display("FAIL corner_%0d_latency: got %0d expected 17", i, lat); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0, b0, a1, b1, r0;
        int lat;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        @(negedge clk);
        op = OP_MUL; op_a = a0; op_b = b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (out_valid) begin lat = c + 0; break; end
        end
        r0 = result;
        chk_cnt++; if (lat !== 17) $display("FAIL bp_latency: got %0d expected 17", lat); else pass_cnt++;
        chk_cnt++; if (r0 !== ref32(OP_MUL, a0, b0)) $display("FAIL bp_result: got %h expected %h", r0, ref32(OP_MUL, a0, b0)); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid_%0d: got %b expected 1", i, out_valid); else pass_cnt++;
            chk_cnt++; if (result !== r0) $display("FAIL bp_hold_result_%0d: got %h expected %h", i, result, r0); else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready_%0d: got %b expected 0", i, in_ready); else pass_cnt++;
        end
        op = OP_MULHU; op_a = a1; op_b = b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b expected 0", out_valid); else pass_cnt++;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (out_valid) begin lat = c + 0; break; end
        end
        chk_cnt++; if (lat !== 17) $display("FAIL b2b_latency: got %0d expected 17", lat); else pass_cnt++;
        chk_cnt++; if (result !== ref32(OP_MULHU, a1, b1)) $display("FAIL b2b_result: got %h expected %h", result, ref32(OP_MULHU, a1, b1)); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int lat;
        bit seen;
        @(negedge clk);
        op = OP_MULH; op_a = $urandom; op_b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready_low: got %b expected 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready_next: got %b expected 1", in_ready); else pass_cnt++;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL flush_no_valid: got %b expected 0", seen); else pass_cnt++;
        run_op(OP_MUL, 32'd3, 32'd5, 0, r, lat);
        chk_cnt++; if (r !== 32'h0000_000F) $display("FAIL flush_after_result: got %h expected 0000000f", r); else pass_cnt++;
        chk_cnt++; if (lat !== 17) $display("FAIL flush_after_latency: got %0d expected 17", lat); else pass_cnt++;
    endtask

    task automatic test_flush_accept();
        bit seen;
        @(negedge clk);
        op = OP_MUL; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_idle_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_idle_not_taken: got %b expected 1", in_ready); else pass_cnt++;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL flush_idle_no_valid: got %b expected 0", seen); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, r;
        int lat;
        @(negedge clk);
        op = OP_MULHSU; op_a = $urandom; op_b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        chk_cnt++; if (result !== 32'h0) $display("FAIL rst_mid_result: got %h expected 00000000", result); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        a = pick32(); b = pick32();
        run_op(OP_MULH, a, b, 0, r, lat);
        chk_cnt++; if (r !== ref32(OP_MULH, a, b)) $display("FAIL rst_after_result: got %h expected %h", r, ref32(OP_MULH, a, b)); else pass_cnt++;
        chk_cnt++; if (lat !== 17) $display("FAIL rst_after_latency: got %0d expected 17", lat); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, e;
        logic [1:0]  o;
        int lat;
        for (int i = 0; i < 300; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick32(); b = pick32();
            e = ref32(o, a, b);
            run_op(o, a, b, $urandom_range(0, 2), r, lat);
            chk_cnt++; if (r !== e) $display("FAIL rand32_%0d_result: op %0d a %h b %h got %h expected %h", i, o, a, b, r, e); else pass_cnt++;
            chk_cnt++; if (lat !== 17) $display("FAIL rand32_%0d_latency: got %0d expected 17", i, lat); else pass_cnt++;
        end
    endtask

    task automatic test_wide();
        logic [63:0] a, b, r, e;
        logic [1:0]  o;
        int lat;
        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick64(); b = pick64();
            e = ref64(o, a, b);
            w_run_op(o, a, b, r, lat);
            chk_cnt++; if (r !== e) $display("FAIL rand64_%0d_result: op %0d a %h b %h got %h expected %h", i, o, a, b, r, e); else pass_cnt++;
            chk_cnt++; if (lat !== 9) $display("FAIL rand64_%0d_latency: got %0d expected 9", i, lat); else pass_cnt++;
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = OP_MUL; op_a = '0; op_b = '0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1; w_op = OP_MUL; w_op_a = '0; w_op_b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_flush();
        test_flush_accept();
        test_reset_mid();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mult_iter.md
Name: mult_iter

Overview:
- Parametrised iterative multiplier for the RV32M/RV64M execute stage.
- Successor to the single-cycle combinational multiplier: trades latency for area by retiring STEP multiplier bits per clock.
- Adds valid/ready handshakes, back-pressure, flush, and a selectable low/high result half per op.
- Sits behind the ALU issue mux; its result feeds the writeback mux.

Parameters:
- XLEN, 32, operand and result width in bits (32 or 64).
- STEP, 2, multiplier bits retired per CALC cycle. Legal values are 1, 2, 4 or 8, and STEP must divide XLEN; anything else is an elaboration error.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight op.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  mult_op_e  MUL, MULH, MULHSU or MULHU.
- op_a  input  XLEN  multiplicand (rs1).
- op_b  input  XLEN  multiplier (rs2).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  selected product half.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out_valid=0; in_ready=1; result=0; counter and accumulator cleared.
- Signedness, latched on accept:
  - MUL, MULHU: a and b unsigned.
  - MULHSU: a signed, b unsigned.
  - MULH: a and b signed.
- Arithmetic:
  - Each operand is extended to XLEN+1 bits with (sign_x & msb).
  - The product of these signed values is formed as a 2*XLEN-bit value.
  - Required method: magnitudes, unsigned shift-add of STEP bits per cycle, then negate at completion if sign_a^sign_b and the product is nonzero.
  - MUL returns product[XLEN-1:0]; all other ops return product[2*XLEN-1:XLEN].
- States:
  - IDLE:
    - in_ready=1.
    - in_valid&in_ready captures op, magnitudes, result-sign and half-select; counter=XLEN/STEP; goes to CALC.
  - CALC:
    - in_ready=0.
    - Each cycle adds (mag_a * next STEP bits of mag_b) into the accumulator at the current offset and decrements the counter.
    - When the counter reaches 1 (the last step), goes to DONE.
  - DONE:
    - out_valid=1; result holds the sign-corrected selected half.
    - result is stable while out_valid&!out_ready.
    - in_ready=out_ready.
    - out_valid&out_ready with no new request goes to IDLE.
    - out_valid&out_ready together with in_valid captures the new request the same cycle and goes to CALC (back-to-back, no bubble).
- Latency:
  - Fixed and data-independent, with no early-out.
  - Accept at edge k; CALC occupies cycles k+1..k+XLEN/STEP; out_valid is high from cycle k+XLEN/STEP+1.
  - XLEN=32, STEP=2: out_valid on cycle 17 after accept.
- Flush:
  - Takes priority over every other event in any state.
  - Next state is IDLE, out_valid=0 next cycle, and any request presented the same cycle is dropped.
  - While flush is high, in_ready is forced 0.
- Operand stability: op_a, op_b and op are sampled only on the accept edge and may change afterwards.
- Reset asserted mid-op aborts immediately to IDLE with no out_valid.
- Corner cases:
  - Divide-by-sign corner cases need no special handling: -2^(XLEN-1) * -2^(XLEN-1) is exact because of the XLEN+1 extension.
  - Zero operands still take the full latency.

Test Plan:
1. XLEN=32, STEP=2: MUL 0x00000007*0x00000006 -> result=0x0000002A; out_valid asserts exactly 17 cycles after accept and stays high 1 cycle with out_ready=1.
2. Signed corners:
   - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
   - MUL same operands -> 0x00000001.
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
   - MULHU same operands -> 0xFFFFFFFE.
3. Back-pressure and back-to-back:
   - Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0.
   - Raise out_ready with in_valid high -> new op accepted the same edge; its result appears 17 cycles later.
4. Flush at cycle 8 of CALC -> no out_valid ever for that op; in_ready=1 the next cycle; a following MUL 3*5 returns 0x0000000F.
5. Reset and flush edge cases:
   - Drop rst_n asynchronously mid-CALC -> out_valid=0 and in_ready=1 without a clock edge; after release, ops compute correctly.
   - Flush asserted together with in_valid in IDLE -> request not accepted.
6. Parameter sweep:
   - XLEN in {32,64} x STEP in {1,2,4,8}.
   - 10k random ops per configuration, including 0, 1, -1, MIN and MAX operands, against a golden 2*XLEN-bit model.
   - Latency checked = XLEN/STEP+1; zero mismatches allowed.
